// File: rtl/alu_seq.sv
// alu_seq: handshaked parametrised ALU with carry chaining and shift-add multiply
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [3:0] op_add = 4'd0;
    localparam logic [3:0] op_sub = 4'd1;
    localparam logic [3:0] op_and = 4'd2;
    localparam logic [3:0] op_or  = 4'd3;
    localparam logic [3:0] op_xor = 4'd4;
    localparam logic [3:0] op_not = 4'd5;
    localparam logic [3:0] op_inc = 4'd6;
    localparam logic [3:0] op_shl = 4'd7;
    localparam logic [3:0] op_shr = 4'd8;
    localparam logic [3:0] op_adc = 4'd9;
    localparam logic [3:0] op_sbb = 4'd10;
    localparam logic [3:0] op_cmp = 4'd11;
    localparam logic [3:0] op_mul = 4'd12;

    typedef enum logic [1:0] {s_idle, s_mul, s_done} state_t;

    state_t               state, state_n;
    logic [2*WIDTH-1:0]   ma, acc, acc_n;
    logic [WIDTH-1:0]     mb, bb, op_r, zn, mul_r;
    logic [WIDTH:0]       sum, dif;
    logic [CW-1:0]        cnt;
    logic [3:0]           op_f, mul_f;
    logic                 op_c, op_v, op_ill, v_add, v_sub, take, is_mul, last;

    assign out_valid = state == s_done;
    assign in_ready  = state == s_idle || (state == s_done && out_ready);
    assign take      = in_valid && in_ready;
    assign is_mul    = opcode == op_mul;
    assign last      = state == s_mul && cnt == CW'(WIDTH - 1);

    // single-cycle datapath; carry-in is the C flag of the last completed op
    always_comb begin
        bb     = opcode == op_inc ? WIDTH'(1) : b;
        sum    = {1'b0, a} + {1'b0, bb} + (WIDTH + 1)'(opcode == op_adc && flags[0]);
        dif    = {1'b0, a} - {1'b0, b} - (WIDTH + 1)'(opcode == op_sbb && flags[0]);
        v_add  = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        v_sub  = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
        op_r   = '0;
        op_c   = 1'b0;
        op_v   = 1'b0;
        case (opcode)
            op_add, op_inc, op_adc: begin
                op_r = sum[WIDTH-1:0];
                op_c = sum[WIDTH];
                op_v = v_add;
            end
            op_sub, op_sbb: begin
                op_r = dif[WIDTH-1:0];
                op_c = dif[WIDTH];
                op_v = v_sub;
            end
            op_cmp: begin
                op_r = a;
                op_c = dif[WIDTH];
                op_v = v_sub;
            end
            op_and: op_r = a & b;
            op_or:  op_r = a | b;
            op_xor: op_r = a ^ b;
            op_not: op_r = ~a;
            op_shl: begin
                op_r = {a[WIDTH-2:0], 1'b0};
                op_c = a[WIDTH-1];
            end
            op_shr: begin
                op_r = {1'b0, a[WIDTH-1:1]};
                op_c = a[0];
            end
            default: ;
        endcase
        zn     = opcode == op_cmp ? dif[WIDTH-1:0] : op_r;
        op_f   = {op_v, zn[WIDTH-1], zn == '0, op_c};
        op_ill = opcode > op_mul;
    end

    // one shift-add step; the final step's sum is the completed product
    always_comb begin
        acc_n = acc + (mb[0] ? ma : '0);
        mul_r = acc_n[WIDTH-1:0];
        mul_f = {1'b0, mul_r[WIDTH-1], mul_r == '0, |acc_n[2*WIDTH-1:WIDTH]};
    end

    // next state: acceptance wins, otherwise finish multiply or release the result
    always_comb begin
        state_n = state;
        if (take)
            state_n = is_mul ? s_mul : s_done;
        else if (last)
            state_n = s_done;
        else if (state == s_done && out_ready)
            state_n = s_idle;
    end

    // state, multiply engine and result registers; outputs change only on completion
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= s_idle;
            result  <= '0;
            flags   <= '0;
            illegal <= 1'b0;
            cnt     <= '0;
            ma      <= '0;
            mb      <= '0;
            acc     <= '0;
        end else begin
            state <= state_n;
            if (take && is_mul) begin
                ma  <= {{WIDTH{1'b0}}, a};
                mb  <= b;
                acc <= '0;
                cnt <= '0;
            end else if (state == s_mul) begin
                ma  <= ma << 1;
                mb  <= mb >> 1;
                acc <= acc_n;
                cnt <= cnt + CW'(1);
            end
            if (take && !is_mul) begin
                result  <= op_r;
                flags   <= op_f;
                illegal <= op_ill;
            end else if (last) begin
                result  <= mul_r;
                flags   <= mul_f;
                illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven scoreboard bench for alu_seq at WIDTH=8
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] opcode = '0;
    logic       in_ready, out_valid, illegal;
    logic [7:0] result;
    logic [3:0] flags;

    typedef struct {
        logic [7:0] r;
        logic [3:0] f;
        logic       ill;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic [3:0] f;
        logic       ill;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // scoreboard: every handshaken result is matched against the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0)
                chk("spurious_out", {31'd0, out_valid}, 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                chk("result", {24'd0, result}, {24'd0, mon_e.r});
                chk("flags", {28'd0, flags}, {28'd0, mon_e.f});
                chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] xa, input logic [7:0] xb,
                        input logic [7:0] er, input logic [3:0] ef, input logic ei);
        int n = 0;
        in_valid = 1'b1;
        opcode   = op;
        a        = xa;
        b        = xb;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(exp_t'{er, ef, ei});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        tbl.push_back(vec_t'{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011, 1'b0});
        tbl.push_back(vec_t'{4'd9,  8'h00, 8'h00, 8'h01, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{4'd1,  8'h00, 8'h01, 8'hFF, 4'b0101, 1'b0});
        tbl.push_back(vec_t'{4'd10, 8'h05, 8'h01, 8'h03, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000, 1'b0});
        tbl.push_back(vec_t'{4'd11, 8'h03, 8'h05, 8'h03, 4'b0101, 1'b0});
        tbl.push_back(vec_t'{4'd0,  8'h7F, 8'h01, 8'h80, 4'b1100, 1'b0});
        tbl.push_back(vec_t'{4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{4'd3,  8'h00, 8'h00, 8'h00, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{4'd4,  8'hAA, 8'h55, 8'hFF, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{4'd5,  8'h0F, 8'h00, 8'hF0, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{4'd6,  8'h7F, 8'h00, 8'h80, 4'b1100, 1'b0});
        tbl.push_back(vec_t'{4'd6,  8'hFF, 8'h00, 8'h00, 4'b0011, 1'b0});
        tbl.push_back(vec_t'{4'd7,  8'h81, 8'h00, 8'h02, 4'b0001, 1'b0});
        tbl.push_back(vec_t'{4'd8,  8'h81, 8'h00, 8'h40, 4'b0001, 1'b0});
        tbl.push_back(vec_t'{4'd9,  8'h7F, 8'h00, 8'h80, 4'b1100, 1'b0});
        tbl.push_back(vec_t'{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0011, 1'b0});
        tbl.push_back(vec_t'{4'd10, 8'h80, 8'h00, 8'h7F, 4'b1000, 1'b0});
        tbl.push_back(vec_t'{4'd11, 8'h05, 8'h05, 8'h05, 4'b0010, 1'b0});
        tbl.push_back(vec_t'{4'd14, 8'h12, 8'h34, 8'h00, 4'b0010, 1'b1});
        tbl.push_back(vec_t'{4'd13, 8'hFF, 8'hFF, 8'h00, 4'b0010, 1'b1});
        tbl.push_back(vec_t'{4'd9,  8'h01, 8'h01, 8'h02, 4'b0000, 1'b0});
        tbl.push_back(vec_t'{4'd12, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b0});
        tbl.push_back(vec_t'{4'd12, 8'h10, 8'h10, 8'h00, 4'b0011, 1'b0});
        tbl.push_back(vec_t'{4'd12, 8'hFF, 8'hFF, 8'h01, 4'b0001, 1'b0});
        tbl.push_back(vec_t'{4'd9,  8'h00, 8'h00, 8'h01, 4'b0000, 1'b0});

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {28'd0, flags}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);

        send(4'd0, 8'hFF, 8'h01, 8'h00, 4'b0011, 1'b0);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_result", {24'd0, result}, 32'd0);
        chk("lat_flags", {28'd0, flags}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", {24'd0, result}, 32'd0);
            chk("hold_flags", {28'd0, flags}, 32'd3);
        end
        out_ready = 1'b1;
        drain();

        foreach (tbl[i])
            send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f, tbl[i].ill);
        drain();

        send(4'd12, 8'h10, 8'h10, 8'h00, 4'b0011, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("mul_busy_valid", {31'd0, out_valid}, 32'd0);
            chk("mul_busy_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
        drain();

        send(4'd7, 8'h81, 8'h00, 8'h02, 4'b0001, 1'b0);
        drain();
        send(4'd12, 8'h0D, 8'h0B, 8'h8F, 4'b0100, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mrst_result", {24'd0, result}, 32'd0);
        chk("mrst_flags", {28'd0, flags}, 32'd0);
        chk("mrst_illegal", {31'd0, illegal}, 32'd0);
        send(4'd9, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
